// File: rtl/sort4_seq.sv
// ---------------------------------------------------------------------------
// sort4_seq
//   Sequential 4-entry sorter for 4-bit unsigned values. Four operands are
//   loaded over a valid/ready input stream. They are sorted in place with a
//   fixed 3-pass x 3-pair bubble-sort schedule, which takes exactly 9 compare
//   cycles. The sorted values are then streamed out over a valid/ready output.
//   Magnitude decisions come from an external A>B comparator: this block
//   drives cmp_a/cmp_b and swaps the current pair when cmp_gt is high.
//
// Parameters
//   DESC       0 = ascending (smallest first), 1 = descending
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data valid this cycle
//   in_data    operand to load (4 bits)
//   in_ready   block accepts in_data (LOAD only)
//   cmp_a      comparator operand A (0 outside SORT)
//   cmp_b      comparator operand B (0 outside SORT)
//   cmp_gt     comparator result, cmp_a > cmp_b
//   out_valid  out_data valid (OUT only)
//   out_data   sorted value (0 outside OUT)
//   out_last   final (4th) output beat
//   out_ready  downstream accepts beat
//   busy       high in SORT and OUT
// ---------------------------------------------------------------------------
module sort4_seq #(
    parameter bit DESC = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic [3:0] cmp_a,
    output logic [3:0] cmp_b,
    input  logic       cmp_gt,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_SORT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      p_q, p_d;
    logic [1:0]      j_q, j_d;
    logic [3:0][3:0] mem_q, mem_d;

    // j only takes 0..2 in SORT, so j+1 stays inside mem.
    logic [1:0]      j_nx;
    assign j_nx = j_q + 2'd1;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        p_d     = p_q;
        j_d     = j_q;
        mem_d   = mem_q;

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    mem_d[idx_q] = in_data;
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        p_d     = 2'd0;
                        j_d     = 2'd0;
                        state_d = S_SORT;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            S_SORT: begin
                // The operand order on cmp_a/cmp_b already encodes the sort
                // direction, so a high cmp_gt always means "swap".
                if (cmp_gt) begin
                    mem_d[j_q]  = mem_q[j_nx];
                    mem_d[j_nx] = mem_q[j_q];
                end
                if (j_q == 2'd2) begin
                    j_d = 2'd0;
                    if (p_q == 2'd2) begin
                        p_d     = 2'd0;
                        idx_d   = 2'd0;
                        state_d = S_OUT;
                    end else begin
                        p_d = p_q + 2'd1;
                    end
                end else begin
                    j_d = j_nx;
                end
            end

            S_OUT: begin
                if (out_ready) begin
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = S_LOAD;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = S_LOAD;
                idx_d   = 2'd0;
                p_d     = 2'd0;
                j_d     = 2'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            idx_q   <= 2'd0;
            p_q     <= 2'd0;
            j_q     <= 2'd0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            p_q     <= p_d;
            j_q     <= j_d;
            mem_q   <= mem_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from registered state and mem only, so there is no
    // combinational path from in_valid or out_ready.
    // -----------------------------------------------------------------------
    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q == S_SORT) || (state_q == S_OUT);

    always_comb begin
        cmp_a = 4'd0;
        cmp_b = 4'd0;
        if (state_q == S_SORT) begin
            // Descending order swaps the operands so that "A > B" still
            // means the pair is out of order.
            if (DESC) begin
                cmp_a = mem_q[j_nx];
                cmp_b = mem_q[j_q];
            end else begin
                cmp_a = mem_q[j_q];
                cmp_b = mem_q[j_nx];
            end
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = 4'd0;
        out_last  = 1'b0;
        if (state_q == S_OUT) begin
            out_valid = 1'b1;
            out_data  = mem_q[idx_q];
            out_last  = (idx_q == 2'd3);
        end
    end

endmodule

// File: tb/tb_sort4_seq.sv
// ---------------------------------------------------------------------------
// tb_sort4_seq
//   Directed bench for sort4_seq. It runs an ascending and a descending
//   instance in lockstep from shared inputs. Each instance has its own
//   behavioural A>B comparator. Inputs change on the falling edge, and
//   outputs are checked there as well.
// ---------------------------------------------------------------------------
module tb_sort4_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;

    logic       in_ready0, in_ready1, busy0, busy1;
    logic [3:0] cmp_a0, cmp_b0, cmp_a1, cmp_b1;
    logic       gt0, gt1;
    logic       out_valid0, out_valid1, out_last0, out_last1;
    logic [3:0] out_data0, out_data1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // External comparators
    assign gt0 = (cmp_a0 > cmp_b0);
    assign gt1 = (cmp_a1 > cmp_b1);

    sort4_seq #(.DESC(1'b0)) u_asc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .cmp_a(cmp_a0), .cmp_b(cmp_b0), .cmp_gt(gt0),
        .out_valid(out_valid0), .out_data(out_data0), .out_last(out_last0),
        .out_ready(out_ready), .busy(busy0)
    );

    sort4_seq #(.DESC(1'b1)) u_dsc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .cmp_a(cmp_a1), .cmp_b(cmp_b1), .cmp_gt(gt1),
        .out_valid(out_valid1), .out_data(out_data1), .out_last(out_last1),
        .out_ready(out_ready), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, {in_ready0, in_ready1}, 2'b11);
        chk({tag, "_busy"}, {busy0, busy1}, 2'b00);
        chk({tag, "_out_valid"}, {out_valid0, out_valid1}, 2'b00);
        chk({tag, "_out_data"}, {out_data0, out_data1}, 8'd0);
        chk({tag, "_out_last"}, {out_last0, out_last1}, 2'b00);
        chk({tag, "_cmp"}, {cmp_a0, cmp_b0, cmp_a1, cmp_b1}, 16'd0);
    endtask

    // v[3] is loaded first.
    task automatic load4(input logic [3:0][3:0] v);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("load_in_ready", {in_ready0, in_ready1}, 2'b11);
            chk("load_busy", {busy0, busy1}, 2'b00);
            chk("load_out_valid", {out_valid0, out_valid1}, 2'b00);
            in_valid = 1'b1;
            in_data  = v[3-i];
        end
    endtask

    // Nine compare cycles. The first compare is on the first two loaded values.
    task automatic sort9(input logic noise, input logic eq_en, input logic [3:0] eq_val,
                         input logic [3:0] fa, input logic [3:0] fb);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            in_valid = noise;
            in_data  = 4'hE;
            chk("sort_busy", {busy0, busy1}, 2'b11);
            chk("sort_in_ready", {in_ready0, in_ready1}, 2'b00);
            chk("sort_out_valid", {out_valid0, out_valid1}, 2'b00);
            if (k == 0) begin
                chk("sort_cmp_asc", {cmp_a0, cmp_b0}, {fa, fb});
                chk("sort_cmp_dsc", {cmp_a1, cmp_b1}, {fb, fa});
            end
            if (eq_en) begin
                chk("eq_cmp", {cmp_a0, cmp_b0, cmp_a1, cmp_b1}, {4{eq_val}});
                chk("eq_gt", {gt0, gt1}, 2'b00);
            end
        end
    endtask

    // ea/ed: expected beats, element [3] first.
    task automatic unload(input logic [3:0][3:0] ea, input logic [3:0][3:0] ed,
                          input logic bp, input logic noise);
        for (int i = 0; i < 4; i++) begin
            if (bp) begin
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    out_ready = 1'b0;
                    in_valid  = noise;
                    chk("stall_valid", {out_valid0, out_valid1}, 2'b11);
                    chk("stall_data", {out_data0, out_data1}, {ea[3-i], ed[3-i]});
                    chk("stall_last", {out_last0, out_last1}, {2{i == 3}});
                end
            end
            @(negedge clk);
            chk("out_valid", {out_valid0, out_valid1}, 2'b11);
            chk("out_data_asc", out_data0, ea[3-i]);
            chk("out_data_dsc", out_data1, ed[3-i]);
            chk("out_last", {out_last0, out_last1}, {2{i == 3}});
            chk("out_in_ready", {in_ready0, in_ready1}, 2'b00);
            chk("out_busy", {busy0, busy1}, 2'b11);
            chk("out_cmp", {cmp_a0, cmp_b0, cmp_a1, cmp_b1}, 16'd0);
            out_ready = 1'b1;
            in_valid  = noise;
            in_data   = 4'hE;
        end
    endtask

    initial begin
        logic [3:0][3:0] ba, bb, ea, da, eb, db;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b1;

        #3;
        chk_idle("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Duplicates, both orders
        load4({4'd9, 4'd3, 4'd12, 4'd3});
        sort9(1'b0, 1'b0, 4'd0, 4'd9, 4'd3);
        unload({4'd3, 4'd3, 4'd9, 4'd12}, {4'd12, 4'd9, 4'd3, 4'd3}, 1'b0, 1'b0);

        // Extremes
        load4({4'd15, 4'd0, 4'd7, 4'd0});
        sort9(1'b0, 1'b0, 4'd0, 4'd15, 4'd0);
        unload({4'd0, 4'd0, 4'd7, 4'd15}, {4'd15, 4'd7, 4'd0, 4'd0}, 1'b0, 1'b0);

        // All equal: never a swap
        load4({4'd5, 4'd5, 4'd5, 4'd5});
        sort9(1'b0, 1'b1, 4'd5, 4'd5, 4'd5);
        unload({4{4'd5}}, {4{4'd5}}, 1'b0, 1'b0);

        // Backpressure, with in_valid noise during SORT and OUT
        load4({4'd1, 4'd2, 4'd3, 4'd4});
        sort9(1'b1, 1'b0, 4'd0, 4'd1, 4'd2);
        unload({4'd1, 4'd2, 4'd3, 4'd4}, {4'd4, 4'd3, 4'd2, 4'd1}, 1'b1, 1'b1);

        // Reset in SORT cycle 5
        load4({4'd8, 4'd1, 4'd6, 4'd2});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("pre_rst_busy", {busy0, busy1}, 2'b11);
        end
        rst_n = 1'b0;
        #1;
        chk_idle("mid_reset");
        @(negedge clk);
        chk_idle("mid_reset_hold");
        rst_n = 1'b1;
        load4({4'd4, 4'd3, 4'd2, 4'd1});
        sort9(1'b0, 1'b0, 4'd0, 4'd4, 4'd3);
        unload({4'd1, 4'd2, 4'd3, 4'd4}, {4'd4, 4'd3, 4'd2, 4'd1}, 1'b0, 1'b0);

        // Back-to-back batches: 17-cycle period
        ba = {4'd7, 4'd1, 4'd4, 4'd2};
        ea = {4'd1, 4'd2, 4'd4, 4'd7};
        da = {4'd7, 4'd4, 4'd2, 4'd1};
        bb = {4'd0, 4'd15, 4'd15, 4'd3};
        eb = {4'd0, 4'd3, 4'd15, 4'd15};
        db = {4'd15, 4'd15, 4'd3, 4'd0};
        out_ready = 1'b1;
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 4'hF;
            if (c < 4) begin
                chk("b2b_in_ready_a", in_ready0, 1'b1);
                in_data = ba[3-c];
            end else if (c < 13) begin
                chk("b2b_sort_a", {busy0, out_valid0}, 2'b10);
            end else if (c < 17) begin
                chk("b2b_valid_a", {out_valid0, out_valid1}, 2'b11);
                chk("b2b_data_a", {out_data0, out_data1}, {ea[16-c], da[16-c]});
                chk("b2b_last_a", out_last0, (c == 16));
            end else if (c < 21) begin
                chk("b2b_in_ready_b", in_ready0, 1'b1);
                in_data = bb[20-c];
            end else if (c < 30) begin
                chk("b2b_sort_b", {busy0, out_valid0}, 2'b10);
            end else begin
                chk("b2b_valid_b", {out_valid0, out_valid1}, 2'b11);
                chk("b2b_data_b", {out_data0, out_data1}, {eb[33-c], db[33-c]});
                chk("b2b_last_b", out_last0, (c == 33));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_end_in_ready", {in_ready0, in_ready1}, 2'b11);
        chk("b2b_end_out_valid", {out_valid0, out_valid1}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sort4_seq.md
# sort4_seq

Sequential 4-entry sorter for 4-bit values. It accepts four operands on a valid/ready input stream and sorts them in place with a fixed bubble-sort schedule. The magnitude decision comes from the team's external 4-bit A>B comparator stage: this block drives that comparator's A/B operands and consumes its greater-than result. It then emits the sorted values on a valid/ready output stream, and is the control stage that sits directly around the comparator.

## Interface
- DESC, default 0: sort order. 0 = ascending (smallest first), 1 = descending.

- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data valid this cycle
- in_data  input  4  operand to load
- in_ready  output  1  block accepts in_data this cycle (high only in LOAD)
- cmp_a  output  4  operand A to external comparator
- cmp_b  output  4  operand B to external comparator
- cmp_gt  input  1  comparator result, 1 when cmp_a > cmp_b (unsigned); combinational from cmp_a/cmp_b
- out_valid  output  1  out_data valid
- out_data  output  4  sorted value
- out_last  output  1  marks 4th (final) output beat
- out_ready  input  1  downstream accepts beat
- busy  output  1  high in SORT and OUT

## Operation
- Storage: mem[0..3], 4 bits each. Counters: load/out index idx (2 bits), pass p (0..2), pair j (0..2).
- States:
  - LOAD: in_ready=1. Each in_valid&in_ready cycle writes mem[idx] and increments idx. The 4th accept (idx=3) sets idx=0, p=0, j=0 and moves to SORT.
  - SORT: one compare per cycle on pair (mem[j], mem[j+1]).
    - DESC=0: cmp_a=mem[j], cmp_b=mem[j+1].
    - DESC=1: cmp_a=mem[j+1], cmp_b=mem[j].
    - If cmp_gt=1 at the rising edge, swap mem[j] and mem[j+1].
    - j advances 0→1→2. When j=2 it wraps to 0 and p increments. After p=2, j=2 the state moves to OUT with idx=0.
    - Always exactly 9 compare cycles, with no early exit.
  - OUT: out_valid=1, out_data=mem[idx], out_last=(idx==3). On out_valid&out_ready idx increments. The final beat returns to LOAD with idx=0.
- Equal operands: cmp_gt=0, so no swap. The sort is stable and never swaps equal values.
- Outside SORT: cmp_a=cmp_b=0. cmp_gt is ignored.
- Outside OUT: out_valid=0, out_data=0, out_last=0.
- in_valid outside LOAD is ignored; in_ready is 0 there.
- Comparison is unsigned 4-bit. No arithmetic on data; mem only loads or swaps.

## Timing
- Reset (rst_n=0, asynchronous):
  - State is LOAD; idx, p, j and all mem are 0.
  - in_ready=1; out_valid=0, out_data=0, out_last=0, busy=0, cmp_a=0, cmp_b=0.
  - These values hold while rst_n is low. Normal operation begins on the first rising edge after deassertion.
- in_ready, out_valid, out_data, out_last, busy, cmp_a and cmp_b are decoded from registered state and mem only, with no combinational path from in_valid or out_ready.
- Latency:
  - Minimum 4 cycles LOAD.
  - Exactly 9 cycles SORT.
  - Minimum 4 cycles OUT.
  - Minimum 17 cycles per batch, back-to-back with no idle cycle.
  - The first out_valid is asserted the cycle after the 9th compare edge.
- Backpressure: while out_ready=0 in OUT, out_data/out_last hold stable and idx does not advance.
- Input gaps: in_valid=0 in LOAD stalls the load with no timeout. Partial loads persist indefinitely.
- Final output beat: on the cycle the final beat is accepted, in_ready is still 0. LOAD (in_ready=1) begins the following cycle.
- Reset mid-operation (any state) discards all data. No out_valid is emitted for the aborted batch.

## Test plan
- DESC=0, load 9,3,12,3 → after 9 SORT cycles output 3,3,9,12. out_last only on 12. First out_valid exactly 9 cycles after 4th accept.
- DESC=1, load 9,3,12,3 → output 12,9,3,3. cmp_a/cmp_b show swapped operand order during SORT.
- DESC=0, load 15,0,7,0 (reverse/extremes) → 0,0,7,15. Load 5,5,5,5 → 5,5,5,5 with cmp_gt never 1 and mem unchanged each cycle.
- Backpressure: hold out_ready=0 for 3 cycles on each beat of 1,2,3,4 → data stable during each stall. Exactly four accepted beats. Assert in_valid during SORT/OUT → ignored, in_ready=0.
- Drop rst_n during SORT cycle 5 after loading 8,1,6,2 → outputs immediately at reset values. After release, load 4,3,2,1 → output 1,2,3,4 only.
- Back-to-back batches with in_valid held high and out_ready=1 → 17-cycle batch period. Second batch loaded correctly starting the cycle after the first batch's out_last.
